// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 single-bit mux, with a one-cycle
// break-before-make gap between owners. Define ARB_TIMEOUT_EN for forced release after HOLD_MAX cycles.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       busy
);

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("mux8_rr_arbiter: HOLD_MAX must be in 2..255");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            sel_valid_q, sel_valid_d;
    logic            busy_q, busy_d;
    logic [SW-1:0]   ptr_q, ptr_d;
`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0]   hold_q, hold_d;
`endif

    // Rotate requests so ptr_q sits at bit 0, then pick the lowest set bit.
    logic [2*N-1:0]  req_dbl_c;
    logic [N-1:0]    req_rot_c;
    logic [SW-1:0]   offset_c;
    logic [SW-1:0]   winner_c;
    logic            release_c;

    always_comb begin
        req_dbl_c = {req, req} >> ptr_q;
        req_rot_c = req_dbl_c[N-1:0];
        offset_c  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot_c[i]) begin
                offset_c = SW'(i);
            end
        end
        winner_c = ptr_q + offset_c;
    end

    // Owner gives the mux back when it drops req, or (optionally) when its time is up and someone waits.
    always_comb begin
        release_c = ~req[sel_q];
`ifdef ARB_TIMEOUT_EN
        if ((hold_q == HOLD_LAST) && (|(req & ~grant_q))) begin
            release_c = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        ptr_d       = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
`endif

        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d     = GRANT;
                    grant_d     = N'(1) << winner_c;
                    sel_d       = winner_c;
                    sel_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end else begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d     = GAP;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                    ptr_d       = sel_q + SW'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                sel_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;

endmodule
